// File: rtl/pc_fetch_unit.sv
// PC owner and instruction-fetch sequencer: one outstanding imem request, responses
// belonging to redirected-away fetches are discarded, fetched words are held for decode.
module pc_fetch_unit #(
  parameter int unsigned        XLEN     = 32,
  parameter logic [XLEN-1:0]    RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCsrc,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic [XLEN-1:0] if_instr,
  output logic            misalign_pulse
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2,
    ST_DROP = 2'd3
  } state_e;

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_pc_plus4_q, if_pc_plus4_d;
  logic [XLEN-1:0] if_instr_q, if_instr_d;
  logic            misalign_q, misalign_d;

  logic [XLEN-1:0] target_aligned;
  logic [XLEN-1:0] pc_plus4;

  assign target_aligned = {branch_target[XLEN-1:2], 2'b00};
  assign pc_plus4       = pc_q + FOUR;
  assign misalign_d     = PCsrc && (branch_target[1:0] != 2'b00);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    if_valid_d     = if_valid_q;
    if_pc_d        = if_pc_q;
    if_pc_plus4_d  = if_pc_plus4_q;
    if_instr_d     = if_instr_q;
    imem_req_valid = 1'b0;

    case (state_q)
      ST_REQ: begin
        // A redirect suppresses the request so the stale pc is never fetched.
        imem_req_valid = !PCsrc && !rst;
        if (PCsrc) begin
          pc_d = target_aligned;
        end else if (imem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (PCsrc) begin
          pc_d    = target_aligned;
          state_d = imem_rsp_valid ? ST_REQ : ST_DROP;
        end else if (imem_rsp_valid) begin
          if_instr_d    = imem_rsp_data;
          if_pc_d       = pc_q;
          if_pc_plus4_d = pc_plus4;
          if_valid_d    = 1'b1;
          pc_d          = pc_plus4;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (PCsrc || if_ready) begin
          if_valid_d = 1'b0;
          state_d    = ST_REQ;
          if (PCsrc) begin
            pc_d = target_aligned;
          end
        end
      end
      ST_DROP: begin
        // The in-flight response still has to drain before a new request may issue.
        if (PCsrc) begin
          pc_d = target_aligned;
        end
        if (imem_rsp_valid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_REQ;
      pc_q          <= RESET_PC;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_pc_plus4_q <= '0;
      if_instr_q    <= '0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_pc_plus4_q <= if_pc_plus4_d;
      if_instr_q    <= if_instr_d;
      misalign_q    <= misalign_d;
    end
  end

  assign imem_req_addr  = pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_pc_plus4    = if_pc_plus4_q;
  assign if_instr       = if_instr_q;
  assign misalign_pulse = misalign_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios then randomized traffic, with a memory
// model feeding a scoreboard of instructions decode is expected to accept, in order.
module tb_pc_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCsrc;
  logic [31:0] branch_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic [31:0] if_instr;
  logic        misalign_pulse;

  always #5 clk = ~clk;

  pc_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .PCsrc(PCsrc), .branch_target(branch_target),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_pc_plus4(if_pc_plus4), .if_instr(if_instr),
    .misalign_pulse(misalign_pulse)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } item_t;

  int n_checks = 0;
  int n_fail   = 0;
  int accepted = 0;

  // Reference model: architectural fetch pc, one pending memory access, redirect epoch.
  item_t       sb[$];
  logic [31:0] exp_pc;
  int unsigned epoch;
  logic        pend;
  logic [31:0] pend_addr;
  logic [31:0] pend_exp;
  int unsigned pend_epoch;
  int          pend_wait;
  logic        late;
  int          rsp_kind;   // 0 none, 1 answers pending request, 2 junk
  int          rsp_delay;  // -1 = random
  bit          ready_always;
  bit          spur_en;
  bit          mon_en = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  function automatic void chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endfunction

  task automatic mem_drive();
    rsp_kind       = 0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    imem_req_ready = ready_always ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (late && !rst) begin
      late           = 1'b0;
      rsp_kind       = 2;
      imem_rsp_valid = 1'b1;
      imem_req_ready = 1'b0;
    end else if (pend) begin
      if (pend_wait == 0) begin
        rsp_kind       = 1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend_addr);
      end else begin
        pend_wait--;
      end
    end else if (spur_en && $urandom_range(0, 7) == 0) begin
      rsp_kind       = 2;
      imem_rsp_valid = 1'b1;
    end
  endtask

  // Evaluated mid-cycle: predicts the effect of the coming rising edge.
  task automatic model_edge();
    item_t it;
    if (rst) begin
      chk1("req_valid_in_rst", imem_req_valid, 1'b0);
      late   = late || (pend && rsp_kind != 1);
      pend   = 1'b0;
      exp_pc = RST_PC;
      epoch++;
      sb.delete();
      return;
    end
    if (rsp_kind == 1) begin
      pend = 1'b0;
      if (pend_epoch == epoch && !PCsrc) begin
        it.pc    = pend_exp;
        it.instr = mem_word(pend_exp);
        sb.push_back(it);
        exp_pc = pend_exp + 32'd4;
      end
    end
    if (PCsrc) chk1("req_valid_on_redirect", imem_req_valid, 1'b0);
    if (imem_req_valid) chk1("single_outstanding", pend, 1'b0);
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_req_addr, exp_pc);
      $display("req  addr=%h", imem_req_addr);
      pend       = 1'b1;
      pend_addr  = imem_req_addr;
      pend_exp   = exp_pc;
      pend_epoch = epoch;
      pend_wait  = (rsp_delay >= 0) ? rsp_delay : int'($urandom_range(0, 3));
    end
    if (PCsrc) begin
      exp_pc = {branch_target[31:2], 2'b00};
      epoch++;
      sb.delete();
    end
  endtask

  task automatic step();
    mem_drive();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: checks every instruction decode accepts against the scoreboard.
  logic  m_prev_mis = 1'b0;
  item_t m_it;
  always @(negedge clk) begin
    if (mon_en) begin
      chk1("misalign_pulse", misalign_pulse, m_prev_mis);
      if (!rst && if_valid) begin
        chk("if_pc_plus4", if_pc_plus4, if_pc + 32'd4);
        if (if_ready && !PCsrc) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_accept: got pc=%h instr=%h expected none", if_pc, if_instr);
          end else begin
            m_it = sb.pop_front();
            chk("if_pc", if_pc, m_it.pc);
            chk("if_instr", if_instr, m_it.instr);
            accepted++;
            $display("dec  pc=%h instr=%h", if_pc, if_instr);
          end
        end
      end
    end
    m_prev_mis = !rst && PCsrc && (branch_target[1:0] != 2'b00);
  end

  initial begin
    rst = 1'b1; PCsrc = 1'b0; branch_target = '0; if_ready = 1'b1;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    exp_pc = RST_PC; epoch = 0; pend = 1'b0; pend_addr = '0; pend_exp = '0;
    pend_epoch = 0; pend_wait = 0; late = 1'b0; rsp_kind = 0;
    rsp_delay = 0; ready_always = 1'b1; spur_en = 1'b0;
    @(posedge clk);
    #1;
    step();
    step();

    // Reset state
    chk1("rst_req_valid", imem_req_valid, 1'b0);
    chk1("rst_if_valid", if_valid, 1'b0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk1("rst_misalign", misalign_pulse, 1'b0);
    mon_en = 1'b1;
    rst    = 1'b0;
    #1;
    chk("first_req_addr", imem_req_addr, RST_PC);
    chk1("first_req_valid", imem_req_valid, 1'b1);

    // Sequential fetch through the wrap point
    step();
    step();
    chk1("wrap_if_valid", if_valid, 1'b1);
    chk("wrap_if_pc", if_pc, RST_PC);
    chk("wrap_if_pc_plus4", if_pc_plus4, 32'h0);
    chk("wrap_if_instr", if_instr, mem_word(RST_PC));
    step();
    chk("wrap_next_addr", imem_req_addr, 32'h0);
    step();
    step();
    chk("seq_if_pc0", if_pc, 32'h0);
    chk("seq_if_instr0", if_instr, mem_word(32'h0));

    // Decode stall in HOLD
    if_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1("stall_if_valid", if_valid, 1'b1);
      chk("stall_if_pc", if_pc, 32'h0);
      chk("stall_if_instr", if_instr, mem_word(32'h0));
      chk1("stall_no_req", imem_req_valid, 1'b0);
    end
    if_ready = 1'b1;
    step();
    chk("stall_next_addr", imem_req_addr, 32'h4);
    chk1("stall_next_valid", imem_req_valid, 1'b1);
    step();
    step();
    chk("seq_if_pc4", if_pc, 32'h4);
    chk("seq_if_pc_plus4_8", if_pc_plus4, 32'h8);
    step();
    chk("seq_req_addr8", imem_req_addr, 32'h8);

    // Redirect while waiting; late response must be dropped
    rsp_delay = 1;
    step();
    PCsrc = 1'b1; branch_target = 32'h100;
    step();
    PCsrc = 1'b0;
    chk1("drop_if_valid_a", if_valid, 1'b0);
    step();
    chk1("drop_if_valid_b", if_valid, 1'b0);
    chk("drop_next_addr", imem_req_addr, 32'h100);
    chk1("drop_next_valid", imem_req_valid, 1'b1);
    rsp_delay = 0;

    // Redirect during HOLD with decode stalled
    step();
    step();
    chk1("hold_redir_valid_before", if_valid, 1'b1);
    if_ready = 1'b0; PCsrc = 1'b1; branch_target = 32'h200;
    step();
    chk1("hold_redir_valid_fall", if_valid, 1'b0);
    chk("hold_redir_addr", imem_req_addr, 32'h200);
    if_ready = 1'b1;

    // Misaligned redirect in REQ
    PCsrc = 1'b1; branch_target = 32'h0000_0106;
    step();
    chk1("misalign_set", misalign_pulse, 1'b1);
    chk("misalign_addr", imem_req_addr, 32'h104);
    PCsrc = 1'b0;
    rsp_delay = 2;
    step();
    chk1("misalign_one_cycle", misalign_pulse, 1'b0);

    // Reset during WAIT; the late response arrives in REQ and is ignored
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("rst_mid_addr", imem_req_addr, RST_PC);
    chk1("rst_mid_req_valid", imem_req_valid, 1'b1);
    chk1("rst_mid_if_valid", if_valid, 1'b0);
    rsp_delay = 0;
    repeat (4) step();

    // Randomized traffic
    ready_always = 1'b0;
    spur_en      = 1'b1;
    rsp_delay    = -1;
    repeat (4000) begin
      PCsrc         = ($urandom_range(0, 15) == 0);
      branch_target = $urandom;
      if_ready      = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; PCsrc = 1'b0; if_ready = 1'b1;
    repeat (20) step();

    n_checks++;
    if (accepted < 50) begin
      n_fail++;
      $display("FAIL accepted_count: got %0d expected at least 50", accepted);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
